pipe_skid_buffer: RTL
=====================

Name: pipe_skid_buffer

Overview:
- Two-entry elastic pipeline register with a valid/ready handshake and synchronous flush.
- It sits between pipeline stages where the downstream stage can stall. It is the consumer-side counterpart of the enable/load stage flop: it absorbs the in-flight word when the stall arrives, so the upstream stall (ready) path is fully registered.
- Flush discards all buffered words, in the same way a load-to-bubble does on a stage register.

Parameters:
- WIDTH, 8, payload width in bits.
- RESETVAL, 0 (WIDTH bits), value driven on out_data after reset or flush while empty.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous active-high reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream word present.
- in_ready  output  1  buffer can accept a word this cycle; driven directly from a flop.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  buffered word presented downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  head payload.
- count  output  2  occupancy, 0..2.

Behaviour:
- Storage:
  - main register holds the head entry; it drives out_data.
  - skid register holds the second entry.
  - States: EMPTY (count 0), ONE (count 1), FULL (count 2).
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - No combinational path from out_ready to in_ready.
  - in_ready = (state != FULL), registered.
  - out_valid = (state != EMPTY), registered.
- Transitions (evaluated when reset=0 and flush=0):
  - EMPTY, in_fire: main<=in_data; go to ONE.
  - ONE, in_fire & out_fire: main<=in_data; stay in ONE.
  - ONE, in_fire & !out_fire: skid<=in_data; go to FULL.
  - ONE, out_fire & !in_fire: go to EMPTY; main keeps its stale value.
  - FULL, out_fire: main<=skid; go to ONE. in_fire cannot occur because in_ready=0.
  - Any other case: hold all state.
- Latency and ordering:
  - A word accepted at edge N appears on out_data/out_valid after edge N (1 cycle) when the buffer was EMPTY.
  - Strict FIFO order; no word is duplicated or dropped except by flush or reset.
- Reset (synchronous, highest priority):
  - state=EMPTY, count=0, out_valid=0, in_ready=1.
  - main<=RESETVAL; skid<=RESETVAL.
  - Mid-operation reset discards buffered words. A handshake in the same cycle is ignored.
- Flush (priority below reset, above all handshakes):
  - Same result as reset: main<=RESETVAL, state EMPTY.
  - in_data presented in the flush cycle is dropped even if in_valid=1 and in_ready=1.
  - out_fire in the flush cycle is still counted as taken by downstream; it does not reappear.
- count:
  - Equals the state encoding and is registered.
  - Never exceeds 2; never underflows.
- Stability:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
  - X on in_data while in_valid=0 must not propagate to state.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then in_valid=0.
  - Required response: out_valid=0, in_ready=1, count=0, out_data=RESETVAL=0x00.
- Streaming:
  - Stimulus: out_ready=1; in_valid=1 with in_data 0x11,0x22,0x33 on consecutive cycles.
  - Required response: out_data shows 0x11,0x22,0x33 one cycle later each, with out_valid=1; count stays 1; in_ready stays 1.
- Stall/skid:
  - Stimulus: accept 0xA1 and 0xA2 with out_ready=0.
  - Required response: count=2, in_ready=0, out_data holds 0xA1.
  - Then raise out_ready for 2 cycles. Required response: 0xA1 then 0xA2 are delivered, count 2→1→0, in_ready=1 after the first out_fire edge.
- Simultaneous in/out in ONE:
  - Stimulus: head 0x55; same cycle in_fire with 0x66 and out_fire.
  - Required response: next cycle out_data=0x66, count=1.
- Flush while FULL:
  - Stimulus: entries 0xB1/0xB2 buffered; flush=1 together with in_valid=1, in_data=0xB3.
  - Required response: next cycle count=0, out_valid=0, in_ready=1. 0xB3 never appears on the output.
- Reset mid-handshake:
  - Stimulus: count=1 (0xC1); assert reset with in_valid=1, out_ready=1.
  - Required response: next cycle EMPTY with out_data=0x00. Neither 0xC1 nor the new input is delivered afterwards.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register with valid/ready handshake and synchronous flush.
// in_ready and out_valid come straight from flops, so no combinational path links the two sides.
module pipe_skid_buffer #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESETVAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = StFull;
                end else if (out_fire) begin
                    // main keeps its stale value; out_valid masks it
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
            main_d  = RESETVAL;
            skid_d  = RESETVAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            main_q      <= RESETVAL;
            skid_q      <= RESETVAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != StFull);
            out_valid_q <= (state_d != StEmpty);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = state_q;

endmodule
